screen_sequencer: RTL and testbench
===================================

# screen_sequencer

Parametrised screen sequencer and framebuffer write arbiter for the game console: generalises the fixed four-screen game wrapper to `NUM_SCREENS` screens.
- Next-screen selection comes from a parameter transition table indexed by the current screen and its 2-bit exit code.
- It optionally wipes the framebuffer on every transition, and holds each non-active screen in reset.
- It sits between the per-screen modules and display pipeline port A.

## Interface
- `NUM_SCREENS`, 4: number of screen modules (2..8).
- `SEL_W`, 3: screen index width; index values ≥ `NUM_SCREENS` are invalid.
- `ADDR_W`, `` `DISP_ADDR_WIDTH ``: framebuffer address width.
- `FB_WORDS`, `` `DISP_DEPTH ``: words written by a clear pass (≥ 1).
- `CLEAR_EN`, 1: 1 = clear the framebuffer on every transition; 0 = no clear.
- `CLEAR_COLOR`, 32'h0000_0000: word written by a clear.
- `START_SCREEN`, 0: screen entered after reset.
- `NEXT_TABLE`, `NUM_SCREENS*4*SEL_W` bits: entry e = cur*4+code, at bits [e*SEL_W +: SEL_W]. The default encodes:
  - 0→1 on any code.
  - 1→2 on code 0, 1→3 on code 1; codes 2 and 3 = 7 (invalid).
  - 2→0 and 3→0 on any code.
- `clk` in 1: system clock.
- `reset` in 1: Already decided — one clock; reset is synchronous and active-high.
- `scr_done` in `NUM_SCREENS`: per-screen exit strobe; level-sampled each cycle.
- `scr_code` in `NUM_SCREENS*2`: per-screen exit code, valid with `scr_done`.
- `scr_fb_we` in `NUM_SCREENS`: per-screen write enable.
- `scr_fb_addr` in `NUM_SCREENS*ADDR_W`: per-screen write address.
- `scr_fb_wdata` in `NUM_SCREENS*32`: per-screen write data.
- `scr_rst` out `NUM_SCREENS`: active-high hold reset, one bit per screen.
- `cur_screen` out `SEL_W`: index of the active or pending screen.
- `busy` out 1: high in CLEAR and ENTER.
- `fb_we` out 1: registered framebuffer write enable.
- `fb_addr` out `ADDR_W`: registered framebuffer write address.
- `fb_wdata` out 32: registered framebuffer write data.

## Operation
- States are RUN, CLEAR and ENTER. There is a clear counter `cnt`, range 0..`FB_WORDS`-1.
- Reset (synchronous, wins over everything):
  - State ← CLEAR if `CLEAR_EN`, else ENTER.
  - `cnt` ← 0, `cur_screen` ← `START_SCREEN`, `scr_rst` ← all ones.
  - `fb_we` ← 0, `fb_addr` ← 0, `fb_wdata` ← 0.
  - `busy` ← 1.
  - A reset mid-clear aborts the pass; the clear restarts from address 0.
- RUN:
  - `scr_rst` is low only for `cur_screen`; `busy` = 0.
  - The fb outputs load the `cur_screen` write port every cycle.
  - Only `scr_done[cur_screen]` is honoured; done from any other screen is ignored.
  - When it is high: nxt = NEXT_TABLE[cur*4+code].
    - If nxt ≥ `NUM_SCREENS`: ignore the strobe and stay in RUN.
    - Otherwise: `cur_screen` ← nxt, `scr_rst` ← all ones, and go to CLEAR (`CLEAR_EN`=1) or ENTER.
  - nxt == cur is legal: the screen is restarted.
- CLEAR:
  - Each cycle the fb outputs load {1, `cnt`, `CLEAR_COLOR`} and `cnt` increments.
  - At `cnt` = `FB_WORDS`-1: `cnt` ← 0, go to ENTER.
  - Screen writes and done strobes are dropped.
- ENTER:
  - One cycle with `fb_we` ← 0 and all `scr_rst` still high; then go to RUN.
  - Done strobes are dropped.

## Timing
- RUN write latency: 1 cycle from screen port to fb outputs.
- The screen's own write in its done cycle T is still forwarded, at T+1.
- Transition with `CLEAR_EN`=1, done sampled in cycle T:
  - `cur_screen` updates and `scr_rst` goes all-high at T+1.
  - Clear writes appear at T+2 .. T+`FB_WORDS`+1, addresses ascending from 0.
  - ENTER is cycle T+`FB_WORDS`+1.
  - RUN starts, and `scr_rst[cur]` falls, at T+`FB_WORDS`+2.
  - The first new-screen write is visible at T+`FB_WORDS`+3 at the earliest.
- Transition with `CLEAR_EN`=0: ENTER at T+1, RUN at T+2; no writes in between.
- After reset deasserts (first non-reset cycle R), timing is the same as a transition with T = R−1.
- `busy` is high exactly in CLEAR and ENTER cycles.
- Done asserted for multiple cycles causes one transition, because the new screen is held in reset.

## Test plan
- **Reset clear** (`FB_WORDS`=8, `CLEAR_COLOR`=32'hDEAD_BEEF):
  - Stimulus: release reset.
  - Required response: 8 writes to addresses 0..7 with data DEADBEEF, then one idle cycle, then `scr_rst`=4'b1110 and `cur_screen`=0.
- **Default table walk**:
  - Stimulus: done on screen 0; then screen 1 with code 1; then screen 3.
  - Required response: `cur_screen` sequence 0→1→3→0, each step followed by a full clear.
- **Invalid and foreign strobes**:
  - Stimulus: screen 1 done with code 2; separately, done on screen 2 while screen 1 is active.
  - Required response: no transition, `busy` stays 0, and writes from screen 1 continue.
- **Write forwarding**:
  - Stimulus: screen 1 writes addr 5, data 32'h0000_00FF in the same cycle it asserts done with code 0.
  - Required response: that write appears at T+1, and the clear starts at T+2.
- **Mid-clear reset and strobe drop**:
  - Stimulus: a done pulse during CLEAR; then reset asserted at `cnt`=3.
  - Required response: the done pulse is ignored; the clear restarts at address 0 and `cur_screen`=`START_SCREEN`.
- **`CLEAR_EN`=0**:
  - Stimulus: a transition from screen 0.
  - Required response: RUN at T+2 with no fb writes between T+2 and T+3 other than the new screen's.

Source files
------------

// File: rtl/screen_sequencer.sv
// Screen sequencer and framebuffer write arbiter: steps through NUM_SCREENS screen
// modules using a parameter transition table and optionally clears the framebuffer between them.
`ifndef DISP_ADDR_WIDTH
`define DISP_ADDR_WIDTH 16
`endif
`ifndef DISP_DEPTH
`define DISP_DEPTH 65536
`endif

module screen_sequencer #(
  parameter int          NUM_SCREENS  = 4,
  parameter int          SEL_W        = 3,
  parameter int          ADDR_W       = `DISP_ADDR_WIDTH,
  parameter int          FB_WORDS     = `DISP_DEPTH,
  parameter bit          CLEAR_EN     = 1'b1,
  parameter logic [31:0] CLEAR_COLOR  = 32'h0000_0000,
  parameter int          START_SCREEN = 0,
  parameter logic [NUM_SCREENS*4*SEL_W-1:0] NEXT_TABLE = {
    3'd0, 3'd0, 3'd0, 3'd0,
    3'd0, 3'd0, 3'd0, 3'd0,
    3'd7, 3'd7, 3'd3, 3'd2,
    3'd1, 3'd1, 3'd1, 3'd1
  }
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_SCREENS-1:0]        scr_done,
  input  logic [NUM_SCREENS*2-1:0]      scr_code,
  input  logic [NUM_SCREENS-1:0]        scr_fb_we,
  input  logic [NUM_SCREENS*ADDR_W-1:0] scr_fb_addr,
  input  logic [NUM_SCREENS*32-1:0]     scr_fb_wdata,
  output logic [NUM_SCREENS-1:0]        scr_rst,
  output logic [SEL_W-1:0]              cur_screen,
  output logic                          busy,
  output logic                          fb_we,
  output logic [ADDR_W-1:0]             fb_addr,
  output logic [31:0]                   fb_wdata
);

  typedef enum logic [1:0] {ST_RUN, ST_CLEAR, ST_ENTER} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      cnt_q, cnt_d;
  logic [SEL_W-1:0]       cur_screen_q, cur_screen_d;
  logic [NUM_SCREENS-1:0] scr_rst_q, scr_rst_d;
  logic                   fb_we_q, fb_we_d;
  logic [ADDR_W-1:0]      fb_addr_q, fb_addr_d;
  logic [31:0]            fb_wdata_q, fb_wdata_d;

  logic                   cur_done;
  logic [1:0]             cur_code;
  logic                   cur_we;
  logic [ADDR_W-1:0]      cur_addr;
  logic [31:0]            cur_wdata;
  logic [SEL_W-1:0]       nxt;
  logic [NUM_SCREENS-1:0] run_rst;

  // Per-screen port mux and table lookup, written as compare loops so every index is constant.
  always_comb begin
    cur_done  = 1'b0;
    cur_code  = '0;
    cur_we    = 1'b0;
    cur_addr  = '0;
    cur_wdata = '0;
    run_rst   = '1;
    for (int unsigned i = 0; i < NUM_SCREENS; i++) begin
      if (cur_screen_q == SEL_W'(i)) begin
        cur_done   = scr_done[i];
        cur_code   = scr_code[i*2 +: 2];
        cur_we     = scr_fb_we[i];
        cur_addr   = scr_fb_addr[i*ADDR_W +: ADDR_W];
        cur_wdata  = scr_fb_wdata[i*32 +: 32];
        run_rst[i] = 1'b0;
      end
    end
    nxt = '0;
    for (int unsigned e = 0; e < NUM_SCREENS*4; e++) begin
      if ({cur_screen_q, cur_code} == (SEL_W+2)'(e))
        nxt = NEXT_TABLE[e*SEL_W +: SEL_W];
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cur_screen_d = cur_screen_q;
    scr_rst_d    = scr_rst_q;
    fb_we_d      = fb_we_q;
    fb_addr_d    = fb_addr_q;
    fb_wdata_d   = fb_wdata_q;
    case (state_q)
      ST_RUN: begin
        fb_we_d    = cur_we;
        fb_addr_d  = cur_addr;
        fb_wdata_d = cur_wdata;
        if (cur_done && (32'(nxt) < 32'(NUM_SCREENS))) begin
          cur_screen_d = nxt;
          scr_rst_d    = '1;
          if (CLEAR_EN) state_d = ST_CLEAR;
          else          state_d = ST_ENTER;
        end
      end
      ST_CLEAR: begin
        fb_we_d    = 1'b1;
        fb_addr_d  = cnt_q;
        fb_wdata_d = CLEAR_COLOR;
        if (cnt_q == ADDR_W'(FB_WORDS - 1)) begin
          cnt_d   = '0;
          state_d = ST_ENTER;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      ST_ENTER: begin
        fb_we_d   = 1'b0;
        scr_rst_d = run_rst;
        state_d   = ST_RUN;
      end
      default: begin
        fb_we_d = 1'b0;
        state_d = ST_ENTER;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if (CLEAR_EN) state_q <= ST_CLEAR;
      else          state_q <= ST_ENTER;
      cnt_q        <= '0;
      cur_screen_q <= SEL_W'(START_SCREEN);
      scr_rst_q    <= '1;
      fb_we_q      <= 1'b0;
      fb_addr_q    <= '0;
      fb_wdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_screen_q <= cur_screen_d;
      scr_rst_q    <= scr_rst_d;
      fb_we_q      <= fb_we_d;
      fb_addr_q    <= fb_addr_d;
      fb_wdata_q   <= fb_wdata_d;
    end
  end

  assign scr_rst    = scr_rst_q;
  assign cur_screen = cur_screen_q;
  assign busy       = (state_q != ST_RUN);
  assign fb_we      = fb_we_q;
  assign fb_addr    = fb_addr_q;
  assign fb_wdata   = fb_wdata_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// Self-checking bench for screen_sequencer: a clearing instance checked through a write
// scoreboard plus inline checks, and a non-clearing instance checked cycle by cycle.
module tb_screen_sequencer;

  localparam int          NS  = 4;
  localparam int          SW  = 3;
  localparam int          AW  = 8;
  localparam int          FBW = 8;
  localparam logic [31:0] CC  = 32'hDEAD_BEEF;

  logic          clk;
  logic          rst_a, rst_b;
  logic [NS-1:0]    done_a, we_a, scr_rst_a, done_b, we_b, scr_rst_b;
  logic [NS*2-1:0]  code_a, code_b;
  logic [NS*AW-1:0] addr_a, addr_b;
  logic [NS*32-1:0] wdata_a, wdata_b;
  logic [SW-1:0]    cur_a, cur_b;
  logic             busy_a, busy_b, fb_we_a, fb_we_b;
  logic [AW-1:0]    fb_addr_a, fb_addr_b;
  logic [31:0]      fb_wdata_a, fb_wdata_b;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;
  wr_t exp_q[$];

  screen_sequencer #(
    .NUM_SCREENS(NS), .SEL_W(SW), .ADDR_W(AW), .FB_WORDS(FBW),
    .CLEAR_EN(1'b1), .CLEAR_COLOR(CC), .START_SCREEN(0)
  ) dut_a (
    .clk(clk), .reset(rst_a), .scr_done(done_a), .scr_code(code_a),
    .scr_fb_we(we_a), .scr_fb_addr(addr_a), .scr_fb_wdata(wdata_a),
    .scr_rst(scr_rst_a), .cur_screen(cur_a), .busy(busy_a),
    .fb_we(fb_we_a), .fb_addr(fb_addr_a), .fb_wdata(fb_wdata_a)
  );

  screen_sequencer #(
    .NUM_SCREENS(NS), .SEL_W(SW), .ADDR_W(AW), .FB_WORDS(FBW),
    .CLEAR_EN(1'b0), .CLEAR_COLOR(CC), .START_SCREEN(0)
  ) dut_b (
    .clk(clk), .reset(rst_b), .scr_done(done_b), .scr_code(code_b),
    .scr_fb_we(we_b), .scr_fb_addr(addr_b), .scr_fb_wdata(wdata_b),
    .scr_rst(scr_rst_b), .cur_screen(cur_b), .busy(busy_b),
    .fb_we(fb_we_b), .fb_addr(fb_addr_b), .fb_wdata(fb_wdata_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every write seen on dut_a must be the oldest one still expected.
  always @(negedge clk) begin
    wr_t w;
    if (fb_we_a === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_write: got addr=%0d data=%h, required no write", fb_addr_a, fb_wdata_a);
      end else begin
        w = exp_q.pop_front();
        if (fb_addr_a !== w.addr || fb_wdata_a !== w.data) begin
          errors++;
          $display("FAIL sb_write: got addr=%0d data=%h, required addr=%0d data=%h",
                   fb_addr_a, fb_wdata_a, w.addr, w.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_clear(input int first, input int last);
    for (int i = first; i <= last; i++) exp_q.push_back('{addr: AW'(i), data: CC});
  endtask

  task automatic test_reset();
    rst_a = 1'b1;
    step();
    step();
    checks++;
    if (cur_a !== 3'd0 || scr_rst_a !== 4'hF || busy_a !== 1'b1 || fb_we_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got cur=%0d rst=%b busy=%b we=%b, required cur=0 rst=1111 busy=1 we=0",
               cur_a, scr_rst_a, busy_a, fb_we_a);
    end
    rst_a = 1'b0;
    push_clear(0, FBW - 1);
    for (int i = 0; i < FBW; i++) begin
      step();
      checks++;
      if (fb_we_a !== 1'b1 || fb_addr_a !== AW'(i)) begin
        errors++;
        $display("FAIL reset_clear_addr: got we=%b addr=%0d, required we=1 addr=%0d", fb_we_a, fb_addr_a, i);
      end
    end
    checks++;
    if (busy_a !== 1'b1 || scr_rst_a !== 4'hF) begin
      errors++;
      $display("FAIL reset_enter: got busy=%b rst=%b, required busy=1 rst=1111", busy_a, scr_rst_a);
    end
    step();
    checks++;
    if (busy_a !== 1'b0 || scr_rst_a !== 4'b1110 || cur_a !== 3'd0 || fb_we_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_run: got busy=%b rst=%b cur=%0d we=%b, required busy=0 rst=1110 cur=0 we=0",
               busy_a, scr_rst_a, cur_a, fb_we_a);
    end
  endtask

  task automatic test_table_walk();
    int scr[3] = '{0, 1, 3};
    int cd[3]  = '{0, 1, 0};
    int nx[3]  = '{1, 3, 0};
    logic [3:0] exp_rst;
    for (int k = 0; k < 3; k++) begin
      done_a = '0;
      code_a = '0;
      done_a[scr[k]] = 1'b1;
      code_a[scr[k]*2 +: 2] = 2'(cd[k]);
      push_clear(0, FBW - 1);
      step();
      done_a = '0;
      checks++;
      if (cur_a !== 3'(nx[k]) || scr_rst_a !== 4'hF || busy_a !== 1'b1) begin
        errors++;
        $display("FAIL walk_select: got cur=%0d rst=%b busy=%b, required cur=%0d rst=1111 busy=1",
                 cur_a, scr_rst_a, busy_a, nx[k]);
      end
      for (int i = 0; i < FBW; i++) step();
      step();
      exp_rst = ~(4'b0001 << nx[k]);
      checks++;
      if (busy_a !== 1'b0 || scr_rst_a !== exp_rst || cur_a !== 3'(nx[k])) begin
        errors++;
        $display("FAIL walk_run: got busy=%b rst=%b cur=%0d, required busy=0 rst=%b cur=%0d",
                 busy_a, scr_rst_a, cur_a, exp_rst, nx[k]);
      end
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL walk_clear_count: got %0d writes outstanding, required 0", exp_q.size());
      end
    end
  endtask

  task automatic test_invalid_strobes();
    done_a = 4'b0001;
    code_a = '0;
    push_clear(0, FBW - 1);
    step();
    done_a = '0;
    repeat (FBW + 1) step();
    we_a = 4'b0010;
    addr_a[AW +: AW] = 8'h21;
    wdata_a[32 +: 32] = 32'hA5A5_0001;
    done_a = 4'b0010;
    code_a[2 +: 2] = 2'd2;
    exp_q.push_back('{addr: 8'h21, data: 32'hA5A5_0001});
    step();
    checks++;
    if (cur_a !== 3'd1 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL invalid_code: got cur=%0d busy=%b, required cur=1 busy=0", cur_a, busy_a);
    end
    done_a = 4'b0100;
    code_a = '0;
    addr_a[AW +: AW] = 8'h22;
    wdata_a[32 +: 32] = 32'hA5A5_0002;
    exp_q.push_back('{addr: 8'h22, data: 32'hA5A5_0002});
    step();
    checks++;
    if (cur_a !== 3'd1 || busy_a !== 1'b0 || scr_rst_a !== 4'b1101) begin
      errors++;
      $display("FAIL foreign_done: got cur=%0d busy=%b rst=%b, required cur=1 busy=0 rst=1101",
               cur_a, busy_a, scr_rst_a);
    end
    done_a = '0;
    we_a = '0;
    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL invalid_writes: got %0d writes outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_write_forwarding();
    we_a = 4'b0010;
    addr_a[AW +: AW] = 8'd5;
    wdata_a[32 +: 32] = 32'h0000_00FF;
    done_a = 4'b0010;
    code_a = '0;
    exp_q.push_back('{addr: 8'd5, data: 32'h0000_00FF});
    push_clear(0, 0);
    step();
    we_a = '0;
    done_a = '0;
    checks++;
    if (fb_we_a !== 1'b1 || fb_addr_a !== 8'd5 || fb_wdata_a !== 32'h0000_00FF || cur_a !== 3'd2 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL fwd_t1: got we=%b addr=%0d data=%h cur=%0d busy=%b, required we=1 addr=5 data=000000ff cur=2 busy=1",
               fb_we_a, fb_addr_a, fb_wdata_a, cur_a, busy_a);
    end
    step();
    checks++;
    if (fb_we_a !== 1'b1 || fb_addr_a !== 8'd0 || fb_wdata_a !== CC) begin
      errors++;
      $display("FAIL fwd_t2_clear: got we=%b addr=%0d data=%h, required we=1 addr=0 data=%h",
               fb_we_a, fb_addr_a, fb_wdata_a, CC);
    end
  endtask

  task automatic test_midclear_reset();
    done_a = 4'b0100;
    code_a = '0;
    push_clear(1, 2);
    step();
    done_a = '0;
    checks++;
    if (cur_a !== 3'd2 || fb_addr_a !== 8'd1) begin
      errors++;
      $display("FAIL clear_drop_done: got cur=%0d addr=%0d, required cur=2 addr=1", cur_a, fb_addr_a);
    end
    step();
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    checks++;
    if (fb_we_a !== 1'b0 || cur_a !== 3'd0 || scr_rst_a !== 4'hF || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL midclear_reset: got we=%b cur=%0d rst=%b busy=%b, required we=0 cur=0 rst=1111 busy=1",
               fb_we_a, cur_a, scr_rst_a, busy_a);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL midclear_partial: got %0d writes outstanding, required 0", exp_q.size());
    end
    push_clear(0, FBW - 1);
    for (int i = 0; i < FBW; i++) begin
      step();
      checks++;
      if (fb_addr_a !== AW'(i)) begin
        errors++;
        $display("FAIL restart_addr: got %0d, required %0d", fb_addr_a, i);
      end
    end
    step();
    checks++;
    if (busy_a !== 1'b0 || scr_rst_a !== 4'b1110 || cur_a !== 3'd0) begin
      errors++;
      $display("FAIL restart_run: got busy=%b rst=%b cur=%0d, required busy=0 rst=1110 cur=0",
               busy_a, scr_rst_a, cur_a);
    end
  endtask

  task automatic test_held_done();
    done_a = 4'b0001;
    code_a = '0;
    push_clear(0, FBW - 1);
    step();
    repeat (FBW + 4) step();
    checks++;
    if (cur_a !== 3'd1 || busy_a !== 1'b0 || scr_rst_a !== 4'b1101) begin
      errors++;
      $display("FAIL held_done: got cur=%0d busy=%b rst=%b, required cur=1 busy=0 rst=1101",
               cur_a, busy_a, scr_rst_a);
    end
    done_a = '0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL held_done_writes: got %0d writes outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_clear_disabled();
    rst_b = 1'b1;
    step();
    checks++;
    if (busy_b !== 1'b1 || fb_we_b !== 1'b0 || cur_b !== 3'd0 || scr_rst_b !== 4'hF) begin
      errors++;
      $display("FAIL noclr_reset: got busy=%b we=%b cur=%0d rst=%b, required busy=1 we=0 cur=0 rst=1111",
               busy_b, fb_we_b, cur_b, scr_rst_b);
    end
    rst_b = 1'b0;
    step();
    checks++;
    if (busy_b !== 1'b0 || scr_rst_b !== 4'b1110 || fb_we_b !== 1'b0) begin
      errors++;
      $display("FAIL noclr_start: got busy=%b rst=%b we=%b, required busy=0 rst=1110 we=0",
               busy_b, scr_rst_b, fb_we_b);
    end
    done_b = 4'b0001;
    we_b = 4'b0010;
    addr_b[AW +: AW] = 8'd9;
    wdata_b[32 +: 32] = 32'h0000_1234;
    step();
    done_b = '0;
    checks++;
    if (cur_b !== 3'd1 || busy_b !== 1'b1 || fb_we_b !== 1'b0 || scr_rst_b !== 4'hF) begin
      errors++;
      $display("FAIL noclr_t1: got cur=%0d busy=%b we=%b rst=%b, required cur=1 busy=1 we=0 rst=1111",
               cur_b, busy_b, fb_we_b, scr_rst_b);
    end
    step();
    checks++;
    if (busy_b !== 1'b0 || fb_we_b !== 1'b0 || scr_rst_b !== 4'b1101) begin
      errors++;
      $display("FAIL noclr_t2: got busy=%b we=%b rst=%b, required busy=0 we=0 rst=1101",
               busy_b, fb_we_b, scr_rst_b);
    end
    step();
    checks++;
    if (fb_we_b !== 1'b1 || fb_addr_b !== 8'd9 || fb_wdata_b !== 32'h0000_1234) begin
      errors++;
      $display("FAIL noclr_t3: got we=%b addr=%0d data=%h, required we=1 addr=9 data=00001234",
               fb_we_b, fb_addr_b, fb_wdata_b);
    end
    we_b = '0;
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    done_a = '0; code_a = '0; we_a = '0; addr_a = '0; wdata_a = '0;
    done_b = '0; code_b = '0; we_b = '0; addr_b = '0; wdata_b = '0;
    test_reset();
    test_table_walk();
    test_invalid_strobes();
    test_write_forwarding();
    test_midclear_reset();
    test_held_done();
    test_clear_disabled();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_scoreboard: got %0d writes outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
